// File: rtl/dot_product_sequencer.sv
// Layer sequencer for the 784-element dot-product datapath: clear, feed rows, drain, capture per neuron.
// Optional argmax tracking is built when DOT_PRODUCT_SEQ_ARGMAX_EN is defined.
module dot_product_sequencer #(
  parameter int unsigned NUM_ROWS    = 28,
  parameter int unsigned NUM_NEURONS = 10,
  parameter int unsigned DP_LATENCY  = 8,
  parameter int unsigned RESULT_W    = 26
) (
  input  logic                clk,
  input  logic                GlobalReset,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output logic                rd_en,
  output logic [4:0]          row_addr,
  output logic [3:0]          neuron_idx,
  output logic                dp_reset_n,
  input  logic [RESULT_W-1:0] dp_value,
  output logic                result_valid,
  output logic [3:0]          result_neuron,
  output logic [RESULT_W-1:0] result_value,
  output logic [3:0]          class_idx,
  output logic [RESULT_W-1:0] class_value
);

  // +1 covers the synchronous row-memory read ahead of the datapath pipeline
  localparam int unsigned DRAIN_CYCLES = DP_LATENCY + 1;
  localparam int unsigned DRAIN_W      = $clog2(DRAIN_CYCLES + 1);
  localparam logic [4:0]         LAST_ROW    = 5'(NUM_ROWS - 1);
  localparam logic [3:0]         LAST_NEURON = 4'(NUM_NEURONS - 1);
  localparam logic [DRAIN_W-1:0] LAST_DRAIN  = DRAIN_W'(DRAIN_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_FEED,
    S_DRAIN,
    S_CAPTURE,
    S_DONE
  } state_e;

  state_e               state_q, state_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 rd_en_q, rd_en_d;
  logic [4:0]           row_q, row_d;
  logic [3:0]           neuron_q, neuron_d;
  logic                 dp_reset_n_q, dp_reset_n_d;
  logic [DRAIN_W-1:0]   drain_q, drain_d;
  logic                 rv_q, rv_d;
  logic [3:0]           rn_q, rn_d;
  logic [RESULT_W-1:0]  rval_q, rval_d;

  // Outputs are registered: each *_d holds the value for the state being entered.
  always_comb begin
    state_d      = state_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    rd_en_d      = 1'b0;
    row_d        = row_q;
    neuron_d     = neuron_q;
    dp_reset_n_d = 1'b1;
    drain_d      = drain_q;
    rv_d         = 1'b0;
    rn_d         = rn_q;
    rval_d       = rval_q;
    unique case (state_q)
      S_IDLE: begin
        busy_d = 1'b0;
        if (start) begin
          state_d      = S_CLEAR;
          busy_d       = 1'b1;
          neuron_d     = '0;
          dp_reset_n_d = 1'b0;
        end
      end
      S_CLEAR: begin
        state_d = S_FEED;
        row_d   = '0;
        rd_en_d = 1'b1;
      end
      S_FEED: begin
        if (row_q == LAST_ROW) begin
          state_d = S_DRAIN;
          row_d   = '0;
          drain_d = '0;
        end else begin
          row_d   = row_q + 5'd1;
          rd_en_d = 1'b1;
        end
      end
      S_DRAIN: begin
        if (drain_q == LAST_DRAIN) state_d = S_CAPTURE;
        else                       drain_d = drain_q + DRAIN_W'(1);
      end
      S_CAPTURE: begin
        rv_d   = 1'b1;
        rn_d   = neuron_q;
        rval_d = dp_value;
        if (neuron_q == LAST_NEURON) begin
          state_d = S_DONE;
          done_d  = 1'b1;
        end else begin
          state_d      = S_CLEAR;
          neuron_d     = neuron_q + 4'd1;
          dp_reset_n_d = 1'b0;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge GlobalReset) begin
    if (GlobalReset) begin
      state_q      <= S_IDLE;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      rd_en_q      <= 1'b0;
      row_q        <= '0;
      neuron_q     <= '0;
      dp_reset_n_q <= 1'b0;
      drain_q      <= '0;
      rv_q         <= 1'b0;
      rn_q         <= '0;
      rval_q       <= '0;
    end else begin
      state_q      <= state_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      rd_en_q      <= rd_en_d;
      row_q        <= row_d;
      neuron_q     <= neuron_d;
      dp_reset_n_q <= dp_reset_n_d;
      drain_q      <= drain_d;
      rv_q         <= rv_d;
      rn_q         <= rn_d;
      rval_q       <= rval_d;
    end
  end

  assign busy          = busy_q;
  assign done          = done_q;
  assign rd_en         = rd_en_q;
  assign row_addr      = row_q;
  assign neuron_idx    = neuron_q;
  assign dp_reset_n    = dp_reset_n_q;
  assign result_valid  = rv_q;
  assign result_neuron = rn_q;
  assign result_value  = rval_q;

`ifdef DOT_PRODUCT_SEQ_ARGMAX_EN
  logic [3:0]          class_idx_q;
  logic [RESULT_W-1:0] class_value_q;
  logic                class_load_d;

  // Strictly-greater replacement keeps the lowest index on ties
  assign class_load_d = (state_q == S_CAPTURE) &&
                        ((neuron_q == '0) || ($signed(dp_value) > $signed(class_value_q)));

  always_ff @(posedge clk or posedge GlobalReset) begin
    if (GlobalReset) begin
      class_idx_q   <= '0;
      class_value_q <= '0;
    end else if ((state_q == S_IDLE) && start) begin
      class_idx_q   <= '0;
      class_value_q <= '0;
    end else if (class_load_d) begin
      class_idx_q   <= neuron_q;
      class_value_q <= dp_value;
    end
  end

  assign class_idx   = class_idx_q;
  assign class_value = class_value_q;
`else
  assign class_idx   = '0;
  assign class_value = '0;
`endif

endmodule

// File: tb/tb_dot_product_sequencer.sv
// Directed bench for dot_product_sequencer with a latency-accurate datapath model.
`timescale 1ns/1ps
module tb_dot_product_sequencer;
  localparam int unsigned RW = 26;
  localparam int unsigned PER_NEURON = 39;
`ifdef DOT_PRODUCT_SEQ_ARGMAX_EN
  localparam bit ARGMAX = 1'b1;
`else
  localparam bit ARGMAX = 1'b0;
`endif

  logic clk = 1'b0;
  logic GlobalReset = 1'b1;
  logic start = 1'b0;
  logic busy, done, rd_en, dp_reset_n, result_valid;
  logic [4:0] row_addr;
  logic [3:0] neuron_idx, result_neuron, class_idx;
  logic [RW-1:0] dp_value, result_value, class_value;

  dot_product_sequencer #(
    .NUM_ROWS(28), .NUM_NEURONS(10), .DP_LATENCY(8), .RESULT_W(RW)
  ) dut (
    .clk(clk), .GlobalReset(GlobalReset), .start(start),
    .busy(busy), .done(done), .rd_en(rd_en), .row_addr(row_addr),
    .neuron_idx(neuron_idx), .dp_reset_n(dp_reset_n), .dp_value(dp_value),
    .result_valid(result_valid), .result_neuron(result_neuron),
    .result_value(result_value), .class_idx(class_idx), .class_value(class_value)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Datapath model: value only valid once all 28 rows have passed read + pipeline latency
  logic [8:0] rd_sr;
  int unsigned rows_seen;
  logic signed [RW-1:0] score [16];
  always @(posedge clk or posedge GlobalReset) begin
    if (GlobalReset) begin
      rd_sr <= '0;
      rows_seen <= 0;
    end else begin
      rd_sr <= {rd_sr[7:0], rd_en};
      if (!dp_reset_n) rows_seen <= 0;
      else if (rd_sr[8]) rows_seen <= rows_seen + 1;
    end
  end
  assign dp_value = (rows_seen == 28) ? score[neuron_idx] : 26'h0000BAD;

  logic [72:0] all_outs;
  assign all_outs = {busy, done, rd_en, result_valid, row_addr, neuron_idx,
                     result_neuron, result_value, class_idx, class_value};

  int unsigned rv_cyc[$];
  logic [3:0] rv_nrn[$];
  logic signed [RW-1:0] rv_val[$];
  int unsigned done_cnt = 0, rd_cnt = 0, clr_cnt = 0, feed_bad = 0;
  int unsigned exp_row = 0;

  always begin
    @(posedge clk);
    #1;
    if (GlobalReset) exp_row = 0;
    else begin
      if (result_valid) begin
        rv_cyc.push_back(cyc);
        rv_nrn.push_back(result_neuron);
        rv_val.push_back(result_value);
      end
      if (done) done_cnt++;
      if (!dp_reset_n) clr_cnt++;
      if (rd_en) begin
        rd_cnt++;
        if (row_addr != 5'(exp_row)) feed_bad++;
        exp_row = (exp_row == 27) ? 0 : exp_row + 1;
      end else begin
        if (exp_row != 0 || row_addr != 5'd0) feed_bad++;
        exp_row = 0;
      end
    end
  end

  int checks = 0, errors = 0;
  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic signed [RW-1:0] score;
    int unsigned          exp_cycle;
    logic [3:0]           exp_neuron;
    logic signed [RW-1:0] exp_value;
  } vec_t;

  vec_t tab_a[10], tab_b[10], tab[10];
  logic [3:0] exp_cidx;
  logic signed [RW-1:0] exp_cval;
  int scores_b[10] = '{5, -3, 9, 9, 2, 0, 0, 0, 0, -1};

  task automatic load_a();
    for (int n = 0; n < 10; n++) begin
      tab[n] = tab_a[n];
      score[n] = tab_a[n].score;
    end
    exp_cidx = ARGMAX ? 4'd9 : 4'd0;
    exp_cval = ARGMAX ? 26'sd1000 : 26'sd0;
  endtask

  task automatic load_b();
    for (int n = 0; n < 10; n++) begin
      tab[n] = tab_b[n];
      score[n] = tab_b[n].score;
    end
    exp_cidx = ARGMAX ? 4'd2 : 4'd0;
    exp_cval = ARGMAX ? 26'sd9 : 26'sd0;
  endtask

  task automatic start_layer(input bit hold, output int unsigned t0);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    t0 = cyc;
    if (!hold) start = 1'b0;
    check("accept busy", busy, 1);
    check("clear dp_reset_n", dp_reset_n, 0);
  endtask

  task automatic wait_done(input int unsigned t0, input bit pulses, input bit hold,
                           output int unsigned dcyc);
    bit found = 1'b0;
    int unsigned rel = 0;
    dcyc = 0;
    for (int i = 0; i < 600 && !found; i++) begin
      @(negedge clk);
      rel = cyc - t0 + 1;
      if (done) begin
        found = 1'b1;
        dcyc = cyc;
      end else begin
        start = hold | (pulses && (rel == 50 || rel == 200));
      end
    end
    if (!hold) start = 1'b0;
    check("done cycle", found ? rel : 0, 391);
    @(negedge clk);
    check("busy after done", busy, 0);
  endtask

  task automatic check_results(input int unsigned base, input int unsigned t0);
    check("rv count", rv_cyc.size() - base, 10);
    for (int n = 0; n < 10; n++) begin
      if (base + n < rv_cyc.size()) begin
        check($sformatf("rv%0d cycle", n), rv_cyc[base+n] - t0 + 1, tab[n].exp_cycle);
        check($sformatf("rv%0d neuron", n), rv_nrn[base+n], tab[n].exp_neuron);
        check($sformatf("rv%0d value", n), rv_val[base+n], tab[n].exp_value);
      end else begin
        check($sformatf("rv%0d missing", n), 0, 1);
      end
    end
    check("class_idx", class_idx, exp_cidx);
    check("class_value", class_value, exp_cval);
  endtask

  initial begin
    int unsigned t0, t1, dcyc, base, rd0, clr0, fb0, dn0;
    int bad;
    for (int n = 0; n < 10; n++) begin
      tab_a[n].score      = RW'(100 * (n + 1));
      tab_a[n].exp_value  = RW'(100 * (n + 1));
      tab_a[n].exp_neuron = 4'(n);
      tab_a[n].exp_cycle  = (n + 1) * PER_NEURON + 1;
      tab_b[n].score      = RW'(scores_b[n]);
      tab_b[n].exp_value  = RW'(scores_b[n]);
      tab_b[n].exp_neuron = 4'(n);
      tab_b[n].exp_cycle  = (n + 1) * PER_NEURON + 1;
    end
    for (int n = 10; n < 16; n++) score[n] = '0;

    // Reset and idle
    GlobalReset = 1'b1;
    repeat (3) @(negedge clk);
    check("reset dp_reset_n", dp_reset_n, 0);
    check("reset outputs", all_outs, 0);
    GlobalReset = 1'b0;
    @(negedge clk);
    check("release dp_reset_n", dp_reset_n, 1);
    check("release outputs", all_outs, 0);
    bad = 0;
    clr0 = clr_cnt;
    repeat (20) begin
      @(negedge clk);
      if (all_outs != '0 || !dp_reset_n) bad++;
    end
    check("idle 20 cycles", bad, 0);
    check("idle no clear", clr_cnt - clr0, 0);

    // Single layer, scores 100..1000
    load_a();
    base = rv_cyc.size(); rd0 = rd_cnt; clr0 = clr_cnt; fb0 = feed_bad; dn0 = done_cnt;
    start_layer(1'b0, t0);
    wait_done(t0, 1'b0, 1'b0, dcyc);
    check_results(base, t0);
    check("rd_en cycles", rd_cnt - rd0, 280);
    check("clear count", clr_cnt - clr0, 10);
    check("feed rows", feed_bad - fb0, 0);
    check("done count", done_cnt - dn0, 1);

    // Argmax with ties and negatives
    load_b();
    base = rv_cyc.size();
    start_layer(1'b0, t0);
    wait_done(t0, 1'b0, 1'b0, dcyc);
    check_results(base, t0);

    // start pulses while busy are ignored
    load_a();
    base = rv_cyc.size(); dn0 = done_cnt;
    start_layer(1'b0, t0);
    wait_done(t0, 1'b1, 1'b0, dcyc);
    repeat (10) @(negedge clk);
    check_results(base, t0);
    check("busy-start done count", done_cnt - dn0, 1);
    check("busy-start idle", busy, 0);

    // Reset during FEED of neuron 2
    base = rv_cyc.size(); dn0 = done_cnt;
    start_layer(1'b0, t0);
    repeat (99) @(negedge clk);
    check("midrun rel", cyc - t0 + 1, 100);
    check("midrun feeding n2", {rd_en, neuron_idx}, {1'b1, 4'd2});
    GlobalReset = 1'b1;
    #1;
    check("midrun async outputs", all_outs, 0);
    check("midrun dp_reset_n", dp_reset_n, 0);
    repeat (2) @(negedge clk);
    GlobalReset = 1'b0;
    repeat (5) @(negedge clk);
    check("aborted no done", done_cnt - dn0, 0);
    check("aborted rv count", rv_cyc.size() - base, 2);
    check("aborted idle", busy, 0);
    base = rv_cyc.size();
    start_layer(1'b0, t0);
    wait_done(t0, 1'b0, 1'b0, dcyc);
    check_results(base, t0);

    // Back-to-back with start held high
    base = rv_cyc.size(); rd0 = rd_cnt; clr0 = clr_cnt; fb0 = feed_bad; dn0 = done_cnt;
    start_layer(1'b1, t0);
    wait_done(t0, 1'b0, 1'b1, dcyc);
    check_results(base, t0);
    @(negedge clk);
    t1 = cyc;
    start = 1'b0;
    check("b2b clear at done+2", {busy, dp_reset_n, 32'(t1 - dcyc)}, {1'b1, 1'b0, 32'd2});
    base = rv_cyc.size();
    wait_done(t1, 1'b0, 1'b0, dcyc);
    check_results(base, t1);
    check("b2b rd_en cycles", rd_cnt - rd0, 560);
    check("b2b clear count", clr_cnt - clr0, 20);
    check("b2b feed rows", feed_bad - fb0, 0);
    check("b2b done count", done_cnt - dn0, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global timeout: actual running required finished");
    $fatal(1, "timeout");
  end

endmodule
